// File: rtl/backing_memory.sv
// backing_memory: word-addressed main memory behind the cache. It takes one
// request at a time and returns one response a fixed LATENCY cycles later.
// The whole array is zero-filled after every reset.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   word address and write data
//   resp_valid/resp_ready response handshake
//   resp_data             read data, or echo of the written data
//   rd_count, wr_count    wrapping 16-bit counts of accepted reads/writes
module backing_memory #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          cnt_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [15:0]         rd_count_q;
    logic [15:0]         wr_count_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // req_ready_q is high exactly while in IDLE, so it doubles as the state test.
    logic accept;
    assign accept = req_ready_q && req_valid;

    // Writes commit at the acceptance edge so a later read sees them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == INIT)
                mem_q[ptr_q] <= '0;
            else if (accept && req_write)
                mem_q[req_addr] <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= INIT;
            ptr_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (&ptr_q) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= 4'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        if (req_write)
                            wr_count_q <= wr_count_q + 16'd1;
                        else
                            rd_count_q <= rd_count_q + 16'd1;
                        if (LATENCY > 1) begin
                            state_q <= BUSY;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= req_write ? req_wdata : mem_q[req_addr];
                        end
                    end
                end
                BUSY: begin
                    // Leaving on the step that takes the counter to zero puts
                    // the response on the bus for the edge N+LATENCY handshake.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= write_q ? wdata_q : mem_q[addr_q];
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;
endmodule

// File: tb/tb_backing_memory.sv
// tb_backing_memory: randomized and directed checks of backing_memory against an array model.
module tb_backing_memory;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [9:0]  req_addr;
    logic [7:0]  req_wdata, resp_data;
    logic [15:0] rd_count, wr_count;
    logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1;
    logic [9:0]  req_addr1;
    logic [7:0]  req_wdata1, resp_data1;
    logic [15:0] rd_count1, wr_count1;

    logic [7:0]  ref_mem [1024];
    int          nr, nw, nvec, nfail;

    always #5 clock = ~clock;

    backing_memory #(.ADDR_W(10), .DATA_W(8), .LATENCY(3)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .rd_count(rd_count), .wr_count(wr_count));

    backing_memory #(.ADDR_W(10), .DATA_W(8), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1),
        .rd_count(rd_count1), .wr_count(wr_count1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds reset for two edges, then verifies the zero-fill takes 1024 cycles.
    task automatic do_reset();
        int n;
        logic seen;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_rd_count", 32'(rd_count), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clock);
            if (req_ready) break;
            seen |= resp_valid;
            n++;
        end
        check("init_cycles", 32'(n), 1024);
        check("init_no_resp", 32'(seen), 0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        nr = 0;
        nw = 0;
    endtask

    task automatic txn(input logic w, input logic [9:0] a, input logic [7:0] d,
                       input int stall, output int acc);
        int k;
        int lat;
        logic [7:0] exp;
        req_write = w;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        resp_ready = (stall == 0);
        k = 0;
        while (!req_ready && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check("accept_wait", 32'(req_ready), 1);
        @(posedge clock);
        acc = int'($time / 10);
        exp = w ? d : ref_mem[a];
        if (w) begin
            ref_mem[a] = d;
            nw++;
        end else begin
            nr++;
        end
        #1;
        req_valid = (stall > 0);
        req_write = 1'b1;
        req_addr = 10'h001;
        req_wdata = 8'hEE;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 50);
        check("latency", 32'(lat), 3);
        check("resp_data", 32'(resp_data), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("bp_resp_valid", 32'(resp_valid), 1);
            check("bp_resp_data", 32'(resp_data), 32'(exp));
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_rd_count", 32'(rd_count), 32'(nr));
            check("bp_wr_count", 32'(wr_count), 32'(nw));
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clock);
        check("post_resp_valid", 32'(resp_valid), 0);
        check("post_req_ready", 32'(req_ready), 1);
        check("rd_count", 32'(rd_count), 32'(nr));
        check("wr_count", 32'(wr_count), 32'(nw));
    endtask

    task automatic txn1(input logic w, input logic [9:0] a, input logic [7:0] d, input logic [7:0] exp);
        int k;
        int lat;
        req_write1 = w;
        req_addr1 = a;
        req_wdata1 = d;
        req_valid1 = 1'b1;
        k = 0;
        while (!req_ready1 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check("l1_accept_wait", 32'(req_ready1), 1);
        @(posedge clock);
        #1 req_valid1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid1 && lat < 50);
        check("l1_latency", 32'(lat), 1);
        check("l1_resp_data", 32'(resp_data1), 32'(exp));
        @(posedge clock);
        @(negedge clock);
        check("l1_post_valid", 32'(resp_valid1), 0);
        check("l1_post_ready", 32'(req_ready1), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int prev;
        int k;
        logic [9:0] a1;
        logic [7:0] d1;
        nvec = 0;
        nfail = 0;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
        req_valid1 = 0; req_write1 = 0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1;
        do_reset();

        txn(1'b0, 10'h3FF, 8'h00, 0, acc);
        txn(1'b1, 10'h2A5, 8'h5C, 0, acc);
        txn(1'b0, 10'h2A5, 8'h00, 0, acc);
        txn(1'b0, 10'h2A5, 8'h00, 5, acc);
        txn(1'b0, 10'h001, 8'h00, 0, acc);

        prev = 0;
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 10'($urandom_range(0, 1023)), 8'h00, 0, acc);
            if (i > 0) check("b2b_spacing", 32'(acc - prev), 4);
            prev = acc;
        end

        for (int i = 0; i < 24; i++)
            txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 8'($urandom),
                $urandom_range(0, 2), acc);

        k = 0;
        req_write = 1'b1; req_addr = 10'h010; req_wdata = 8'hFF; req_valid = 1'b1;
        while (!req_ready && k < 2000) begin
            @(negedge clock);
            k++;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("midbusy_no_resp", 32'(resp_valid), 0);
        @(posedge clock);
        #1 reset = 1'b1;
        do_reset();
        txn(1'b0, 10'h010, 8'h00, 0, acc);
        txn(1'b1, 10'h3FF, 8'hA5, 1, acc);
        txn(1'b0, 10'h3FF, 8'h00, 0, acc);

        a1 = 10'($urandom_range(0, 1023));
        d1 = 8'($urandom_range(1, 255));
        txn1(1'b0, a1, 8'h00, 8'h00);
        txn1(1'b1, a1, d1, d1);
        txn1(1'b0, a1, 8'h00, d1);
        check("l1_rd_count", 32'(rd_count1), 2);
        check("l1_wr_count", 32'(wr_count1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
